// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the EX-stage forwarding and load-use hazard unit.
package fwd_pkg;

  // Select value meaning "take the register file / ID/EX value".
  localparam int unsigned SEL_RF = 0;

  // Stall FSM encoding.
  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StBubble = 1'b1;

  // Select value that routes in-flight stage k.
  function automatic int unsigned sel_of(input int unsigned k);
    return k + 1;
  endfunction

  // Ceiling log2, usable in parameter defaults.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_match.sv
// Priority match of one source operand against every in-flight writeback stage.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_STG = 2,
  parameter int unsigned AW      = 5,
  parameter int unsigned SEL_W   = clog2(NUM_STG + 1)
) (
  input  logic                   valid_i,
  input  logic                   used_i,
  input  logic [AW-1:0]          src_i,
  input  logic [NUM_STG*AW-1:0]  stg_rd_i,
  input  logic [NUM_STG-1:0]     stg_rw_i,
  input  logic [NUM_STG-1:0]     stg_load_i,
  output logic [SEL_W-1:0]       sel_o,
  output logic                   hit_load_o,
  output logic                   hit_stg0_o
);

  logic [NUM_STG-1:0] hit;

  // x0 is hardwired to zero and must never be forwarded.
  always_comb begin
    hit = '0;
    for (int k = 0; k < int'(NUM_STG); k++) begin
      hit[k] = valid_i && used_i && (src_i != '0) && stg_rw_i[k] &&
               (stg_rd_i[k*AW +: AW] == src_i);
    end
  end

  // Walk from oldest to youngest so the youngest match is the last write.
  always_comb begin
    sel_o      = SEL_W'(SEL_RF);
    hit_load_o = 1'b0;
    for (int k = int'(NUM_STG) - 1; k >= 0; k--) begin
      if (hit[k]) begin
        sel_o      = SEL_W'(sel_of(k));
        hit_load_o = stg_load_i[k];
      end
    end
  end

  assign hit_stg0_o = hit[0];

endmodule

// File: rtl/fwd_hazard_unit.sv
// Registered EX operand forward selects plus load-use stall detection with a bubble FSM.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned NUM_STG  = 2,
  parameter int unsigned AW       = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned SEL_W    = clog2(NUM_STG + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     id_valid_i,
  input  logic [NUM_SRC*AW-1:0]    id_src_i,
  input  logic [NUM_SRC-1:0]       id_src_used_i,
  input  logic [NUM_STG*AW-1:0]    stg_rd_i,
  input  logic [NUM_STG-1:0]       stg_rw_i,
  input  logic [NUM_STG-1:0]       stg_load_i,
  input  logic                     hold_i,
  input  logic                     flush_i,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel_o,
  output logic                     stall_o,
  output logic [15:0]              fwd_cnt_o
);

  localparam int unsigned CntW = 3;
  localparam logic [CntW-1:0] BubbleInit = CntW'(LOAD_LAT - 1);

  logic [SEL_W-1:0]         sel_raw [NUM_SRC];
  logic [NUM_SRC-1:0]       hit_load;
  logic [NUM_SRC-1:0]       hit_stg0;
  logic                     hazard;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_nxt;

  logic [0:0]               state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_q, fwd_sel_d;
  logic [15:0]              fwd_cnt_q, fwd_cnt_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
    fwd_match #(
      .NUM_STG (NUM_STG),
      .AW      (AW),
      .SEL_W   (SEL_W)
    ) u_match (
      .valid_i    (id_valid_i),
      .used_i     (id_src_used_i[i]),
      .src_i      (id_src_i[i*AW +: AW]),
      .stg_rd_i   (stg_rd_i),
      .stg_rw_i   (stg_rw_i),
      .stg_load_i (stg_load_i),
      .sel_o      (sel_raw[i]),
      .hit_load_o (hit_load[i]),
      .hit_stg0_o (hit_stg0[i])
    );
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      hazard = hazard | (hit_stg0[i] & stg_load_i[0]);
    end
  end

  // A bubble stall does not re-check the hazard; only IDLE evaluates it.
  always_comb begin
    stall_o = !rst_i && !flush_i && ((state_q == StBubble) || hazard);
  end

  // A stalled consumer is not issuing, so its load-sourced selects are dropped.
  always_comb begin
    fwd_sel_nxt = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (!(stall_o && hit_load[i])) begin
        fwd_sel_nxt[i*SEL_W +: SEL_W] = sel_raw[i];
      end
    end
  end

  always_comb begin
    fwd_sel_d = fwd_sel_q;
    if (flush_i) begin
      fwd_sel_d = '0;
    end else if (!hold_i) begin
      fwd_sel_d = fwd_sel_nxt;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (!hold_i) begin
      unique case (state_q)
        StIdle: begin
          if (hazard && (LOAD_LAT > 1)) begin
            state_d = StBubble;
            cnt_d   = BubbleInit;
          end
        end
        StBubble: begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    fwd_cnt_d = fwd_cnt_q;
    if (!hold_i && !flush_i && (fwd_sel_nxt != '0) && (fwd_cnt_q != 16'hFFFF)) begin
      fwd_cnt_d = fwd_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      fwd_sel_q <= '0;
      fwd_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fwd_sel_q <= fwd_sel_d;
      fwd_cnt_q <= fwd_cnt_d;
    end
  end

  assign fwd_sel_o = fwd_sel_q;
  assign fwd_cnt_o = fwd_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit with LOAD_LAT=2 and LOAD_LAT=3 instances on shared inputs.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [9:0]  id_src;
  logic [1:0]  id_used;
  logic [9:0]  stg_rd;
  logic [1:0]  stg_rw;
  logic [1:0]  stg_load;
  logic        hold;
  logic        flush;

  logic [3:0]  sel2, sel3;
  logic        stall2, stall3;
  logic [15:0] cnt2, cnt3;

  logic [3:0]  exp_q [$];
  logic [3:0]  e;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(
    .NUM_SRC (2), .NUM_STG (2), .AW (5), .LOAD_LAT (2)
  ) u_dut2 (
    .clk_i (clk), .rst_i (rst), .id_valid_i (id_valid), .id_src_i (id_src),
    .id_src_used_i (id_used), .stg_rd_i (stg_rd), .stg_rw_i (stg_rw),
    .stg_load_i (stg_load), .hold_i (hold), .flush_i (flush),
    .fwd_sel_o (sel2), .stall_o (stall2), .fwd_cnt_o (cnt2)
  );

  fwd_hazard_unit #(
    .NUM_SRC (2), .NUM_STG (2), .AW (5), .LOAD_LAT (3)
  ) u_dut3 (
    .clk_i (clk), .rst_i (rst), .id_valid_i (id_valid), .id_src_i (id_src),
    .id_src_used_i (id_used), .stg_rd_i (stg_rd), .stg_rw_i (stg_rw),
    .stg_load_i (stg_load), .hold_i (hold), .flush_i (flush),
    .fwd_sel_o (sel3), .stall_o (stall3), .fwd_cnt_o (cnt3)
  );

  task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] u, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [1:0] w, input logic [1:0] l, input logic h,
                       input logic f);
    id_valid = v;
    id_src   = {s1, s0};
    id_used  = u;
    stg_rd   = {r1, r0};
    stg_rw   = w;
    stg_load = l;
    hold     = h;
    flush    = f;
  endtask

  task automatic drive_idle();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive_idle();
    tick();
    rst = 1'b0;
  endtask

  // Independent reference for one operand with no loads in flight.
  function automatic logic [1:0] model_sel(input logic v, input logic u, input logic [4:0] s,
                                           input logic [4:0] r0, input logic [4:0] r1,
                                           input logic [1:0] w);
    if (!v || !u || s == 5'd0) return 2'd0;
    if (w[0] && r0 == s) return 2'd1;
    if (w[1] && r1 == s) return 2'd2;
    return 2'd0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd7, 5'd0, 2'b01, 2'b01, 1'b0, 1'b0);
    tick();
    n_cmp++; if (sel2 !== 4'h0) begin n_bad++; $display("FAIL reset_sel2: got %h want 0", sel2); end
    n_cmp++; if (sel3 !== 4'h0) begin n_bad++; $display("FAIL reset_sel3: got %h want 0", sel3); end
    n_cmp++; if (cnt2 !== 16'h0) begin n_bad++; $display("FAIL reset_cnt2: got %h want 0", cnt2); end
    n_cmp++; if (stall2 !== 1'b0) begin n_bad++; $display("FAIL reset_stall2: got %b want 0", stall2); end
    drive_idle();
    rst = 1'b0;
    #1;
    n_cmp++; if (stall3 !== 1'b0) begin n_bad++; $display("FAIL reset_stall3: got %b want 0", stall3); end
  endtask

  task automatic test_stage0();
    reset_dut();
    drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd5, 5'd0, 2'b01, 2'b00, 1'b0, 1'b0);
    exp_q.push_back(4'b0001);
    #1;
    n_cmp++; if (stall2 !== 1'b0) begin n_bad++; $display("FAIL stage0_stall: got %b want 0", stall2); end
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (sel2 !== e) begin n_bad++; $display("FAIL stage0_sel: got %h want %h", sel2, e); end
    n_cmp++; if (cnt2 !== 16'd1) begin n_bad++; $display("FAIL stage0_cnt: got %0d want 1", cnt2); end
    drive_idle();
    exp_q.push_back(4'b0000);
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (sel2 !== e) begin n_bad++; $display("FAIL stage0_clear: got %h want %h", sel2, e); end
    n_cmp++; if (cnt2 !== 16'd1) begin n_bad++; $display("FAIL stage0_cnt_hold: got %0d want 1", cnt2); end
  endtask

  task automatic test_priority();
    logic [4:0] s0_t [3] = '{5'd0, 5'd0, 5'd3};
    logic [4:0] s1_t [3] = '{5'd5, 5'd5, 5'd9};
    logic [4:0] r0_t [3] = '{5'd5, 5'd5, 5'd9};
    logic [4:0] r1_t [3] = '{5'd5, 5'd5, 5'd3};
    logic [1:0] w_t  [3] = '{2'b11, 2'b10, 2'b11};
    logic [3:0] x_t  [3] = '{4'b0100, 4'b1000, 4'b0110};
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, s0_t[i], s1_t[i], 2'b11, r0_t[i], r1_t[i], w_t[i], 2'b00, 1'b0, 1'b0);
      exp_q.push_back(x_t[i]);
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (sel2 !== e) begin n_bad++; $display("FAIL priority_%0d: got %h want %h", i, sel2, e); end
    end
  endtask

  task automatic test_load_use();
    reset_dut();
    drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd7, 5'd0, 2'b01, 2'b01, 1'b0, 1'b0);
    exp_q.push_back(4'b0000);
    #1;
    n_cmp++; if (stall2 !== 1'b1) begin n_bad++; $display("FAIL lu_stall_a: got %b want 1", stall2); end
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (sel2 !== e) begin n_bad++; $display("FAIL lu_sel_a: got %h want %h", sel2, e); end
    drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 5'd7, 2'b10, 2'b10, 1'b0, 1'b0);
    exp_q.push_back(4'b0000);
    #1;
    n_cmp++; if (stall2 !== 1'b1) begin n_bad++; $display("FAIL lu_stall_b: got %b want 1", stall2); end
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (sel2 !== e) begin n_bad++; $display("FAIL lu_sel_b: got %h want %h", sel2, e); end
    drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 5'd7, 2'b10, 2'b00, 1'b0, 1'b0);
    exp_q.push_back(4'b0010);
    #1;
    n_cmp++; if (stall2 !== 1'b0) begin n_bad++; $display("FAIL lu_stall_c: got %b want 0", stall2); end
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (sel2 !== e) begin n_bad++; $display("FAIL lu_sel_c: got %h want %h", sel2, e); end
    n_cmp++; if (cnt2 !== 16'd1) begin n_bad++; $display("FAIL lu_cnt: got %0d want 1", cnt2); end
  endtask

  task automatic test_x0_unused();
    logic       v_t  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [4:0] s0_t [5] = '{5'd0, 5'd0, 5'd0, 5'd6, 5'd0};
    logic [4:0] s1_t [5] = '{5'd0, 5'd0, 5'd6, 5'd6, 5'd6};
    logic [1:0] u_t  [5] = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b11};
    logic [4:0] r0_t [5] = '{5'd0, 5'd0, 5'd6, 5'd6, 5'd6};
    logic [1:0] w_t  [5] = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b01};
    logic [1:0] l_t  [5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    logic [3:0] x_t  [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      drive(v_t[i], s0_t[i], s1_t[i], u_t[i], r0_t[i], 5'd0, w_t[i], l_t[i], 1'b0, 1'b0);
      exp_q.push_back(x_t[i]);
      #1;
      n_cmp++;
      if (stall2 !== 1'b0) begin n_bad++; $display("FAIL x0_stall_%0d: got %b want 0", i, stall2); end
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (sel2 !== e) begin n_bad++; $display("FAIL x0_sel_%0d: got %h want %h", i, sel2, e); end
    end
  endtask

  task automatic test_flush_bubble();
    reset_dut();
    drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd7, 5'd0, 2'b01, 2'b01, 1'b0, 1'b0);
    exp_q.push_back(4'b0000);
    #1;
    n_cmp++; if (stall3 !== 1'b1) begin n_bad++; $display("FAIL fl_stall_a: got %b want 1", stall3); end
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (sel3 !== e) begin n_bad++; $display("FAIL fl_sel_a: got %h want %h", sel3, e); end
    drive(1'b1, 5'd7, 5'd4, 2'b11, 5'd4, 5'd7, 2'b11, 2'b10, 1'b0, 1'b1);
    exp_q.push_back(4'b0000);
    #1;
    n_cmp++; if (stall3 !== 1'b0) begin n_bad++; $display("FAIL fl_stall_b: got %b want 0", stall3); end
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (sel3 !== e) begin n_bad++; $display("FAIL fl_sel_b: got %h want %h", sel3, e); end
    drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd5, 5'd0, 2'b01, 2'b00, 1'b0, 1'b0);
    exp_q.push_back(4'b0001);
    #1;
    n_cmp++; if (stall3 !== 1'b0) begin n_bad++; $display("FAIL fl_idle: got %b want 0", stall3); end
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (sel3 !== e) begin n_bad++; $display("FAIL fl_sel_c: got %h want %h", sel3, e); end
    // Flush must override a simultaneous hold.
    drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd5, 5'd0, 2'b01, 2'b00, 1'b1, 1'b1);
    exp_q.push_back(4'b0000);
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (sel3 !== e) begin n_bad++; $display("FAIL fl_over_hold: got %h want %h", sel3, e); end
    n_cmp++; if (cnt3 !== 16'd1) begin n_bad++; $display("FAIL fl_cnt: got %0d want 1", cnt3); end
  endtask

  task automatic test_hold_bubble();
    logic st_t [3] = '{1'b1, 1'b1, 1'b0};
    reset_dut();
    drive(1'b1, 5'd7, 5'd4, 2'b11, 5'd7, 5'd4, 2'b11, 2'b01, 1'b0, 1'b0);
    exp_q.push_back(4'b1000);
    #1;
    n_cmp++; if (stall3 !== 1'b1) begin n_bad++; $display("FAIL hd_stall_a: got %b want 1", stall3); end
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (sel3 !== e) begin n_bad++; $display("FAIL hd_sel_a: got %h want %h", sel3, e); end
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 1'b0);
      exp_q.push_back(4'b1000);
      #1;
      n_cmp++;
      if (stall3 !== 1'b1) begin n_bad++; $display("FAIL hd_stall_h%0d: got %b want 1", j, stall3); end
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (sel3 !== e) begin n_bad++; $display("FAIL hd_sel_h%0d: got %h want %h", j, sel3, e); end
      n_cmp++;
      if (cnt3 !== 16'd1) begin n_bad++; $display("FAIL hd_cnt_h%0d: got %0d want 1", j, cnt3); end
    end
    for (int j = 0; j < 3; j++) begin
      drive_idle();
      exp_q.push_back(4'b0000);
      #1;
      n_cmp++;
      if (stall3 !== st_t[j]) begin
        n_bad++; $display("FAIL hd_stall_r%0d: got %b want %b", j, stall3, st_t[j]);
      end
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (sel3 !== e) begin n_bad++; $display("FAIL hd_sel_r%0d: got %h want %h", j, sel3, e); end
    end
  endtask

  task automatic test_reset_mid_stall();
    reset_dut();
    drive(1'b1, 5'd7, 5'd4, 2'b11, 5'd7, 5'd4, 2'b11, 2'b01, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 1'b1);
    exp_q.push_back(4'b0000);
    tick();
    rst = 1'b0;
    drive_idle();
    #1;
    e = exp_q.pop_front();
    n_cmp++; if (sel3 !== e) begin n_bad++; $display("FAIL rst_mid_sel: got %h want %h", sel3, e); end
    n_cmp++; if (cnt3 !== 16'd0) begin n_bad++; $display("FAIL rst_mid_cnt: got %0d want 0", cnt3); end
    n_cmp++; if (stall3 !== 1'b0) begin n_bad++; $display("FAIL rst_mid_stall: got %b want 0", stall3); end
  endtask

  task automatic test_back_to_back();
    logic       v;
    logic [1:0] u, w;
    logic [4:0] s0, s1, r0, r1;
    logic [3:0] x;
    int         cnt_exp;
    reset_dut();
    cnt_exp = 0;
    for (int i = 0; i < 24; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      u  = 2'($urandom_range(0, 3));
      w  = 2'($urandom_range(0, 3));
      s0 = 5'($urandom_range(0, 3));
      s1 = 5'($urandom_range(0, 3));
      r0 = 5'($urandom_range(0, 3));
      r1 = 5'($urandom_range(0, 3));
      drive(v, s0, s1, u, r0, r1, w, 2'b00, 1'b0, 1'b0);
      x = {model_sel(v, u[1], s1, r0, r1, w), model_sel(v, u[0], s0, r0, r1, w)};
      if (x != 4'h0) cnt_exp++;
      exp_q.push_back(x);
      #1;
      n_cmp++;
      if (stall2 !== 1'b0) begin n_bad++; $display("FAIL b2b_stall_%0d: got %b want 0", i, stall2); end
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (sel2 !== e) begin n_bad++; $display("FAIL b2b_sel_%0d: got %h want %h", i, sel2, e); end
    end
    n_cmp++;
    if (cnt2 !== 16'(cnt_exp)) begin
      n_bad++; $display("FAIL b2b_cnt: got %0d want %0d", cnt2, cnt_exp);
    end
  endtask

  task automatic test_saturate();
    reset_dut();
    drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd5, 5'd0, 2'b01, 2'b00, 1'b0, 1'b0);
    repeat (65540) @(posedge clk);
    #1;
    n_cmp++; if (cnt2 !== 16'hFFFF) begin n_bad++; $display("FAIL sat_cnt: got %h want ffff", cnt2); end
    n_cmp++; if (sel2 !== 4'b0001) begin n_bad++; $display("FAIL sat_sel: got %h want 1", sel2); end
    drive_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_stage0();
    test_priority();
    test_load_use();
    test_x0_unused();
    test_flush_bubble();
    test_hold_bubble();
    test_reset_mid_stall();
    test_back_to_back();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the 2-stage EX forwarding logic.
- Serves NUM_SRC source operands against NUM_STG in-flight writeback stages, with youngest-stage priority.
- Adds load-use stall detection, with a multi-cycle stall FSM for loads of latency LOAD_LAT.
- Sits beside the ID/EX pipeline register. It samples ID-stage operands and produces registered forward selects that are valid while that instruction is in EX.

Parameters:
- NUM_SRC, 2, number of source operands per instruction (rs1, rs2, optional rs3).
- NUM_STG, 2, number of forwarding stages. Stage 0 is the youngest, the instruction currently in EX.
- AW, 5, register address width.
- LOAD_LAT, 1, bubble cycles required between a load and a dependent consumer (1..4).
- SEL_W, $clog2(NUM_STG+1), forward-select width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID-stage instruction is valid
- id_src  in  NUM_SRC*AW  ID source register addresses, packed; operand i at [i*AW +: AW]
- id_src_used  in  NUM_SRC  operand i is actually read
- stg_rd  in  NUM_STG*AW  destination register per in-flight stage, packed
- stg_rw  in  NUM_STG  register-write enable per stage
- stg_load  in  NUM_STG  stage holds a load whose data is not yet available
- hold  in  1  pipeline frozen externally (cache miss); unit state holds
- flush  in  1  branch/exception flush of ID and EX
- fwd_sel  out  NUM_SRC*SEL_W  registered select per operand: 0 = register file / ID/EX value, k+1 = stage k
- stall  out  1  freeze PC and IF/ID, and insert a bubble into ID/EX
- fwd_cnt  out  16  saturating count of cycles with at least one nonzero forward select

Behaviour:
- Reset (rst high at posedge): fwd_sel=0, stall=0, FSM=IDLE, bubble counter=0, fwd_cnt=0. rst dominates flush and hold.
- Match rule for operand i against stage k:
  - id_valid and id_src_used[i]
  - id_src[i] != 0
  - stg_rw[k]
  - stg_rd[k] == id_src[i]
- Select rule: lowest matching k wins, giving fwd_sel_next[i] = k+1; no match gives 0.
- With NUM_STG=2 the encoding equals the legacy 00/01/10 scheme.
- Lookahead: stage inputs describe the pipeline one cycle before the consumer enters EX. stage k now becomes distance k+1 when fwd_sel is used.
- fwd_sel updates on the rising edge; latency is 1 cycle, no negedge logic.
- Load-use hazard (combinational): any operand matches stage 0 and stg_load[0]=1.
- Stall FSM:
  - IDLE: on a hazard, stall=1 (combinational). If LOAD_LAT>1, go to BUBBLE with counter=LOAD_LAT-1; otherwise stay in IDLE.
  - BUBBLE: stall=1 unconditionally and the counter decrements each cycle. At counter==1, return to IDLE.
  - A BUBBLE stall does not re-check the hazard; IDLE re-evaluates it on exit.
- While stall=1, fwd_sel_next forces operands that match a load stage to 0 (consumer not issuing). All other selects evaluate normally.
- hold=1: FSM, counter, fwd_sel and fwd_cnt keep their values. stall output keeps its current value.
- flush=1 (and no rst):
  - next fwd_sel=0, FSM to IDLE, counter to 0.
  - stall forced to 0 in the same cycle.
  - fwd_cnt unaffected.
- flush together with hold: flush wins.
- fwd_cnt increments on each posedge where a nonzero fwd_sel is registered and hold=0. It saturates at 16'hFFFF.
- x0 never forwards, even when a stage writes x0 with stg_rw=1.

Decomposition:
- Package fwd_pkg holds: SEL_RF=0, the stage-select function sel_of(k)=k+1, FSM state enum {IDLE, BUBBLE}, and the clog2 helper.
- One sub-module, fwd_match: combinational priority match for a single operand against all stages, instanced NUM_SRC times.
- The top level holds the FSM, registers and counter.

Test Plan:
- Dependency on stage 0: NUM_STG=2; id_src[0]=5, stg_rd[0]=5, stg_rw=2'b01, no load → next cycle fwd_sel[0]=1, stall=0, fwd_cnt=1.
- Priority: stg_rd={5,5}, stg_rw=2'b11, id_src[1]=5 → fwd_sel[1]=1, not 2. Then stg_rw=2'b10 → fwd_sel[1]=2.
- Load-use with LOAD_LAT=2: stg_load[0]=1, stg_rd[0]=7, id_src[0]=7 → stall high for exactly 2 cycles with fwd_sel[0]=0. Next cycle stg_rd[1]=7, stg_rw[1]=1, stall drops and fwd_sel[0]=2.
- x0 and unused operands:
  - id_src[0]=0, stg_rd[0]=0, stg_rw=1 → fwd_sel[0]=0.
  - id_src_used[1]=0 with a matching rd → fwd_sel[1]=0 and stall=0.
- Flush mid-bubble: LOAD_LAT=3, hazard, flush asserted in the 2nd stall cycle → stall=0 that cycle, fwd_sel=0 after the edge, FSM=IDLE.
- Hold and reset: assert hold during BUBBLE for 3 cycles → stall and counter frozen, then resume for the remaining cycles. Assert rst mid-stall → all outputs 0 after one edge.
